// File: rtl/turn_signal_seq.sv
// -----------------------------------------------------------------------------
// turn_signal_seq
//
// Sequential turn-signal lamp driver. A request picks one of three patterns:
//   LEFT/RIGHT : the lamps on the chosen side fill outward one lamp per step,
//                then go dark for one step ("all-off"), then repeat while the
//                request is still held.
//   HAZ        : all lamps on both sides blink together, with one step on and
//                one step off.
// A prescaler divides clk so that one sequence step lasts DIV cycles.
//
// Parameters
//   NLAMPS : lamps per side (1..8)
//   DIV    : clock cycles per sequence step (1..65535)
//
// Ports
//   clk    : single clock; all state changes happen on its rising edge
//   reset  : asynchronous, active-high reset
//   left   : left-turn request (level)
//   right  : right-turn request (level)
//   hazard : hazard request (level)
//   la     : left lamps, bit 0 innermost (registered)
//   ra     : right lamps, bit 0 innermost (registered)
//   busy   : high whenever the sequencer is not idle (registered)
// -----------------------------------------------------------------------------
module turn_signal_seq #(
    parameter int NLAMPS = 3,
    parameter int DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              left,
    input  logic              right,
    input  logic              hazard,
    output logic [NLAMPS-1:0] la,
    output logic [NLAMPS-1:0] ra,
    output logic              busy
);

    localparam int PW = $clog2(NLAMPS + 1);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(NLAMPS);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    // Request latched in IDLE; the sequencer enters it on the following edge.
    // IDLE in this register means "nothing pending".
    state_t            pend_q, pend_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NLAMPS-1:0] la_q, la_d;
    logic [NLAMPS-1:0] ra_q, ra_d;
    logic              busy_q, busy_d;

    logic              step;
    logic              haz_req;
    logic              same_req;
    state_t            req_sel;
    logic [NLAMPS-1:0] fill;

    assign step     = (cnt_q == CNT_LAST);
    // Both turn requests at once is treated as a hazard request.
    assign haz_req  = hazard | (left & right);
    assign same_req = (state_q == LEFT) ? left : right;

    // Thermometer pattern for the next position: lamp k lit when k < pos.
    for (genvar gi = 0; gi < NLAMPS; gi++) begin : g_fill
        assign fill[gi] = (PW'(gi) < pos_d);
    end

    always_comb begin
        req_sel = IDLE;
        if (haz_req) begin
            req_sel = HAZ;
        end else if (left) begin
            req_sel = LEFT;
        end else if (right) begin
            req_sel = RIGHT;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        pend_d  = IDLE;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pos_d = '0;
                if (pend_q != IDLE) begin
                    state_d = pend_q;
                    pos_d   = POS_ONE;
                end else begin
                    pend_d = req_sel;
                end
            end

            LEFT, RIGHT: begin
                if (step) begin
                    cnt_d = '0;
                    if (hazard) begin
                        state_d = HAZ;
                        pos_d   = POS_ONE;
                    end else if (pos_q == '0) begin
                        // End of the all-off step: repeat only if still requested.
                        if (same_req) begin
                            pos_d = POS_ONE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (pos_q == POS_LAST) begin
                        pos_d = '0;
                    end else begin
                        pos_d = pos_q + POS_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            HAZ: begin
                if (step) begin
                    cnt_d = '0;
                    if (pos_q != '0) begin
                        pos_d = '0;
                    end else if (haz_req) begin
                        pos_d = POS_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                pos_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the lamp registers change on
    // the same edge as the state, keeping every output a plain flop.
    always_comb begin
        la_d   = '0;
        ra_d   = '0;
        busy_d = (state_d != IDLE);
        case (state_d)
            LEFT:    la_d = fill;
            RIGHT:   ra_d = fill;
            HAZ: begin
                la_d = {NLAMPS{pos_d != '0}};
                ra_d = {NLAMPS{pos_d != '0}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
            la_q    <= '0;
            ra_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            la_q    <= la_d;
            ra_q    <= ra_d;
            busy_q  <= busy_d;
        end
    end

    assign la   = la_q;
    assign ra   = ra_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// -----------------------------------------------------------------------------
// tb_turn_signal_seq
//
// Drives two instances (NLAMPS=3/DIV=2 and NLAMPS=1/DIV=1) with shared
// randomized request patterns and compares lamps and busy each cycle against
// a behavioural model of the sequencing rules. Asynchronous reset pulses are
// inserted mid-cycle and checked before the next clock edge.
// -----------------------------------------------------------------------------
module tb_turn_signal_seq;

    localparam int NA = 3;
    localparam int DA = 2;
    localparam int NB = 1;
    localparam int DB = 1;

    // Model modes
    localparam int M_IDLE = 0;
    localparam int M_LEFT = 1;
    localparam int M_RIGHT = 2;
    localparam int M_HAZ = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          left, right, hazard;
    logic [NA-1:0] la_a, ra_a;
    logic          busy_a;
    logic [NB-1:0] la_b, ra_b;
    logic          busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int mode;   // current pattern
        int lit;    // lamps lit (LEFT/RIGHT) or blink phase on/off (HAZ)
        int tick;   // cycles already spent in the current step
        int want;   // request seen in IDLE, entered on the next edge
    } mdl_t;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    turn_signal_seq #(.NLAMPS(NA), .DIV(DA)) dut_a (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .la(la_a), .ra(ra_a), .busy(busy_a)
    );

    turn_signal_seq #(.NLAMPS(NB), .DIV(DB)) dut_b (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .la(la_b), .ra(ra_b), .busy(busy_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_idle();
        mdl_t m;
        m.mode = M_IDLE;
        m.lit  = 0;
        m.tick = 0;
        m.want = M_IDLE;
        return m;
    endfunction

    // One clock of the sequencing rules for a side with n lamps and d cycles/step.
    function automatic mdl_t mdl_step(mdl_t m, bit l, bit r, bit h, int n, int d);
        mdl_t nx = m;
        bit   both = h || (l && r);
        if (m.mode == M_IDLE) begin
            if (m.want != M_IDLE) begin
                nx.mode = m.want;
                nx.lit  = 1;
                nx.tick = 0;
                nx.want = M_IDLE;
            end else begin
                nx.want = both ? M_HAZ : (l ? M_LEFT : (r ? M_RIGHT : M_IDLE));
            end
            return nx;
        end
        nx.tick = m.tick + 1;
        if (nx.tick < d) return nx;
        nx.tick = 0;
        if (m.mode == M_HAZ) begin
            if (m.lit != 0)  nx.lit = 0;
            else if (both)   nx.lit = 1;
            else             nx = mdl_idle();
        end else if (h) begin
            nx.mode = M_HAZ;
            nx.lit  = 1;
        end else if (m.lit == 0) begin
            if ((m.mode == M_LEFT && l) || (m.mode == M_RIGHT && r)) nx.lit = 1;
            else nx = mdl_idle();
        end else begin
            nx.lit = (m.lit == n) ? 0 : m.lit + 1;
        end
        return nx;
    endfunction

    function automatic int exp_side(mdl_t m, int side, int n);
        if (m.mode == M_HAZ) return (m.lit != 0) ? ((1 << n) - 1) : 0;
        if (m.mode == side)  return (1 << m.lit) - 1;
        return 0;
    endfunction

    task automatic check_all(input string ph);
        check({ph, "_la_a"},   int'(la_a),   exp_side(ma, M_LEFT, NA));
        check({ph, "_ra_a"},   int'(ra_a),   exp_side(ma, M_RIGHT, NA));
        check({ph, "_busy_a"}, int'(busy_a), int'(ma.mode != M_IDLE));
        check({ph, "_la_b"},   int'(la_b),   exp_side(mb, M_LEFT, NB));
        check({ph, "_ra_b"},   int'(ra_b),   exp_side(mb, M_RIGHT, NB));
        check({ph, "_busy_b"}, int'(busy_b), int'(mb.mode != M_IDLE));
    endtask

    initial begin
        int pattern = 1;
        ma     = mdl_idle();
        mb     = mdl_idle();
        reset  = 1'b1;
        left   = 1'b1;
        right  = 1'b0;
        hazard = 1'b1;
        // Requests present during reset must have no effect.
        repeat (3) begin
            @(negedge clk);
            check_all("in_reset");
        end
        reset  = 1'b0;
        hazard = 1'b0;

        for (int cyc = 0; cyc < 700; cyc++) begin
            @(posedge clk);
            ma = mdl_step(ma, left, right, hazard, NA, DA);
            mb = mdl_step(mb, left, right, hazard, NB, DB);
            @(negedge clk);
            check_all("cyc");
            $display("cyc %0d l=%b r=%b h=%b | A la=%b ra=%b busy=%b | B la=%b ra=%b busy=%b",
                     cyc, left, right, hazard, la_a, ra_a, busy_a, la_b, ra_b, busy_b);

            // Pick a new request pattern every 16 cycles; the first block holds left.
            if (cyc > 30 && (cyc % 16) == 0) pattern = $urandom_range(0, 6);
            case (pattern)
                0: begin left = 1'b0; right = 1'b0; hazard = 1'b0; end
                1: begin left = 1'b1; right = 1'b0; hazard = 1'b0; end
                2: begin left = 1'b0; right = 1'b1; hazard = 1'b0; end
                3: begin left = 1'b0; right = 1'b0; hazard = 1'b1; end
                4: begin left = 1'b1; right = 1'b1; hazard = 1'b0; end
                5: begin
                    left   = ($urandom_range(0, 3) == 0);
                    right  = ($urandom_range(0, 3) == 0);
                    hazard = ($urandom_range(0, 9) == 0);
                end
                default: begin
                    left   = 1'b1;
                    right  = 1'b0;
                    hazard = ($urandom_range(0, 7) == 0);
                end
            endcase

            // Mid-cycle asynchronous reset pulse; outputs must clear before the next edge.
            if ((cyc % 97) == 50) begin
                #2 reset = 1'b1;
                #1;
                ma = mdl_idle();
                mb = mdl_idle();
                check_all("async_rst");
                #1 reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/turn_signal_seq.md
TURN_SIGNAL_SEQ -- requirements
Module: turn_signal_seq

Interface
REQ-001 SHALL have parameter NLAMPS, default 3, meaning lamps per side; legal range 1..8.
REQ-002 SHALL have parameter DIV, default 1, meaning clock cycles per sequence step; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port left  input  1  left-turn request, level-sensitive.
REQ-006 SHALL have port right  input  1  right-turn request, level-sensitive.
REQ-007 SHALL have port hazard  input  1  hazard request, level-sensitive.
REQ-008 SHALL have port la  output  NLAMPS  left lamps; bit 0 is the innermost lamp.
REQ-009 SHALL have port ra  output  NLAMPS  right lamps; bit 0 is the innermost lamp.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL drive every output directly from registers (Moore), with no combinational path from inputs.

Function
REQ-012 SHALL implement states IDLE, LEFT, RIGHT and HAZ, plus step position pos (0..NLAMPS) and prescaler cnt (0..DIV-1).
- REQ-013 SHALL generate a step boundary when cnt==DIV-1 and wrap cnt to 0.
- cnt SHALL be held at 0 in IDLE.
REQ-014 SHALL, in IDLE, evaluate requests every cycle with this priority:
- hazard, or left&right together, -> HAZ
- left -> LEFT
- right -> RIGHT
- none -> stay in IDLE.
REQ-015 SHALL make the transition out of IDLE one cycle after the request is sampled, entering with pos=1 and cnt=0.
REQ-016 SHALL, in LEFT, set la[k]=1 for k<pos and la[k]=0 otherwise, with ra all 0; RIGHT mirrors this onto ra with la all 0.
REQ-017 SHALL, in LEFT or RIGHT at each step boundary, advance pos as follows:
- pos 1..NLAMPS-1 -> pos+1
- pos NLAMPS -> pos 0 (all lamps off)
- pos 0 -> pos 1 if the same-side request is still high, else IDLE.
REQ-018 SHALL let a started LEFT/RIGHT frame run through the all-off step regardless of its request dropping; the opposite-side request is ignored until IDLE.
REQ-019 SHALL, if hazard is high at any step boundary in LEFT or RIGHT, transition to HAZ at that boundary with pos=1 and cnt=0.
REQ-020 SHALL, in HAZ, drive all la and ra bits to 1 when pos==1 and all to 0 when pos==0.
- pos SHALL toggle at each step boundary.
- At the boundary ending pos==0, SHALL stay in HAZ (pos=1) if hazard or left&right is high, else go to IDLE.
REQ-021 SHALL give a full LEFT/RIGHT frame length of (NLAMPS+1)*DIV cycles and a full HAZ period of 2*DIV cycles.
REQ-022 SHALL, with DIV=1, produce a step boundary every cycle.
REQ-023 SHALL, with NLAMPS=1, alternate a single lamp on/off in LEFT/RIGHT.

Reset
REQ-024 SHALL, while reset is high, immediately force state=IDLE, pos=0, cnt=0, la=0, ra=0 and busy=0, independent of clk.
REQ-025 SHALL, when reset is asserted mid-frame, abandon the sequence; after release the block SHALL start fresh from IDLE per REQ-014/REQ-015.
REQ-026 SHALL ignore requests present during reset until the first rising edge after reset deasserts.

Verification (NLAMPS=3, DIV=2 unless stated)
REQ-027 SHALL pass: left held continuously -> la = 001,001,011,011,111,111,000,000 then repeat; ra=000 and busy=1 throughout.
REQ-028 SHALL pass: right high one cycle, then low -> ra = 001,011,111,000, each for 2 cycles, then IDLE, busy=0 and ra=000.
REQ-029 SHALL pass: hazard raised while la=011 -> at the next boundary la=ra=111 for 2 cycles, then 000 for 2 cycles, repeating while hazard holds; hazard drop -> IDLE after the off phase.
REQ-030 SHALL pass: left and right raised in the same IDLE cycle -> HAZ entered, la=ra=111 on the next cycle.
REQ-031 SHALL pass: reset pulsed asynchronously while la=111 -> la=ra=000 and busy=0 before the next clk edge; with left still held, la=001 on the second edge after release.
REQ-032 SHALL pass, with DIV=1 and NLAMPS=1: left held -> la toggles 1,0,1,0 every cycle.
